// File: rtl/axis_frame_pkg.sv
// Shared types and helpers for the AXI-Stream frame packer.
package axis_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } state_e;

    localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hA5A5;
    localparam int          AXIS_DATA_W       = 32;

    function automatic logic [31:0] build_header(input logic [15:0] magic,
                                                 input logic [15:0] seq);
        return {magic, seq};
    endfunction

endpackage

// File: rtl/axis_frame_packer_if.sv
// AXI-Stream bundle used on both sides of the frame packer.
interface axis_frame_packer_if
    import axis_frame_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W
) ();

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/axis_out_reg.sv
// Single-stage AXI-Stream register slice: loads a word, holds it while stalled,
// and drops valid once the word is taken with nothing new behind it.
module axis_out_reg
    import axis_frame_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              tready,
    output logic              tvalid,
    output logic [DATA_W-1:0] tdata,
    output logic              tlast,
    output logic              out_free
);

    logic              tvalid_q, tvalid_d;
    logic [DATA_W-1:0] tdata_q,  tdata_d;
    logic              tlast_q,  tlast_d;

    // The slot is free when empty or when its word leaves this cycle.
    assign out_free = !tvalid_q || tready;

    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = load_data;
            tlast_d  = load_last;
        end else if (tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
        end
    end

    assign tvalid = tvalid_q;
    assign tdata  = tdata_q;
    assign tlast  = tlast_q;

endmodule

// File: rtl/axis_frame_packer.sv
// Wraps a headerless sample stream into frames of one header word plus
// FRAME_LEN payload words, with frame and drop counters for status readback.
module axis_frame_packer
    import axis_frame_pkg::*;
#(
    parameter int          FRAME_LEN = 2304,
    parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEFAULT,
    parameter int          CNT_W     = 16
) (
    input  logic                axis_clk,
    input  logic                rst,
    input  logic                enable,
    axis_frame_packer_if.slave  s_axis,
    axis_frame_packer_if.master m_axis,
    output logic                busy,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic [CNT_W-1:0]    drop_cnt
);

    localparam int              WC_W     = $clog2(FRAME_LEN);
    localparam logic [WC_W-1:0] LAST_IDX = WC_W'(FRAME_LEN - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  seq_q, seq_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              load;
    logic [31:0]       load_data;
    logic              load_last;
    logic              out_free;
    logic              s_ready;

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        word_cnt_d  = word_cnt_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        load        = 1'b0;
        load_data   = '0;
        load_last   = 1'b0;
        s_ready     = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = HDR;
                end else if (s_axis.tvalid && (drop_cnt_q != '1)) begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end
            HDR: begin
                if (out_free) begin
                    load       = 1'b1;
                    load_data  = build_header(HDR_MAGIC, 16'(seq_q));
                    word_cnt_d = '0;
                    state_d    = PAY;
                end
            end
            PAY: begin
                // Upstream ready follows the output slot directly; no skid buffer.
                s_ready = out_free;
                if (s_axis.tvalid && out_free) begin
                    load       = 1'b1;
                    load_data  = s_axis.tdata;
                    load_last  = (word_cnt_q == LAST_IDX);
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == LAST_IDX) begin
                        word_cnt_d  = '0;
                        seq_d       = seq_q + 1'b1;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            seq_q       <= '0;
            word_cnt_q  <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            word_cnt_q  <= word_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    axis_out_reg #(
        .DATA_W (32)
    ) u_out_reg (
        .clk       (axis_clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .tready    (m_axis.tready),
        .tvalid    (m_axis.tvalid),
        .tdata     (m_axis.tdata),
        .tlast     (m_axis.tlast),
        .out_free  (out_free)
    );

    assign s_axis.tready = s_ready;
    assign busy          = (state_q != IDLE);
    assign frame_cnt     = frame_cnt_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: doc/axis_frame_packer.md
Name: axis_frame_packer

Overview:
- Sits directly downstream of conv_top's AXI-Stream TX port (axis_clk domain). Consumes the headerless 32-bit sample stream and emits framed packets for the link layer.
- Each frame is one header word followed by FRAME_LEN payload words, with tlast on the last payload word.
- A single registered output stage provides full valid/ready backpressure, and frame and drop counters are exported for status readback.

Parameters:
- FRAME_LEN, 2304, payload words per frame (range 2..65535).
- HDR_MAGIC, 16'hA5A5, upper 16 bits of the header word.
- CNT_W, 16, width of the sequence and status counters.

Ports:
- axis_clk  in  1  stream clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  allows a new frame to start; sampled only in IDLE.
- s_axis_tvalid  in  1  upstream word valid (from conv_top axis_tx_tvalid).
- s_axis_tready  out  1  upstream ready.
- s_axis_tdata  in  32  upstream sample word.
- m_axis_tvalid  out  1  framed word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  32  header or payload word.
- m_axis_tlast  out  1  last payload word of a frame.
- busy  out  1  state is not IDLE.
- frame_cnt  out  CNT_W  number of completed frames (wraps).
- drop_cnt  out  CNT_W  input beats offered while in IDLE with enable low (saturates).

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0, busy=0, seq=0, word_cnt=0, frame_cnt=0, drop_cnt=0.
- Reset mid-frame aborts immediately. The partial frame is discarded with no tlast, and m_axis_tvalid drops the next cycle even if the beat was not accepted.
- Define out_free = !m_axis_tvalid || m_axis_tready, computed combinationally.
- FSM states:
  - IDLE: if enable=1, go to HDR. Otherwise s_axis_tready=0, and each cycle with s_axis_tvalid=1 increments drop_cnt (saturating at all-ones).
  - HDR: when out_free, load the output register with {HDR_MAGIC, seq[15:0]}, tlast=0, then go to PAY with word_cnt=0. s_axis_tready=0 in this state.
  - PAY: s_axis_tready = out_free (combinational). On an input handshake:
    - load the output register with s_axis_tdata;
    - set tlast = (word_cnt == FRAME_LEN-1);
    - increment word_cnt.
  - On the handshake with word_cnt == FRAME_LEN-1: seq++, frame_cnt++ (both wrap), then go to IDLE.
- enable falling during HDR or PAY does not abort; the current frame completes.
- Output register: holds its value while m_axis_tvalid=1 and m_axis_tready=0 (AXIS stability rule). It clears valid when m_axis_tready=1 and no new word is loaded.
- Latency: s_axis handshake to m_axis_tvalid is 1 cycle.
- Throughput: 1 word/cycle within a frame. Overhead per frame: the header cycle plus one IDLE cycle, so a frame takes FRAME_LEN+2 cycles minimum.
- Combinational path: m_axis_tready to s_axis_tready is an accepted single combinational path. There is no skid buffer.
- busy = (state != IDLE).
- Simultaneous events:
  - A downstream accept in the same cycle as a new load: the new word replaces the old one, and valid stays 1.
  - tlast beat stalled while enable is low: the FSM is already in IDLE, and the output register still holds the word until it is accepted.
- word_cnt width = clog2(FRAME_LEN). The seq field is 16 bits regardless of CNT_W; seq is truncated or zero-extended to 16 bits.

Decomposition:
- Package axis_frame_pkg:
  - state enum (IDLE, HDR, PAY);
  - HDR_MAGIC default;
  - header-build function (magic, seq) returning 32 bits.
- One natural sub-module: axis_out_reg. It is the single-stage AXIS register slice (load, hold, tvalid/tdata/tlast) and is reusable on other conv_top outputs. Counters and FSM stay in the top.

Test Plan:
1. FRAME_LEN=4, enable=1, tready=1, input words 1,2,3,4. Output must be A5A50000, 1, 2, 3, 4(tlast=1), one word per cycle after the header, with frame_cnt=1 afterward.
2. Two back-to-back frames with inputs 10..17. Header words must be A5A50000 then A5A50001, there must be exactly one IDLE gap cycle between frames, and frame_cnt=2.
3. Backpressure with tready toggled 1,0,0,1 pseudo-randomly. Every output word must stay stable while stalled, no input word may be lost or duplicated, and tlast must appear only on the 4th payload word.
4. enable=0 with s_axis_tvalid held high for 5 cycles. Required: s_axis_tready=0, drop_cnt=5, no output. Then raise enable: the header must be emitted next cycle with seq=0.
5. enable deasserted after payload word 2 of 4. The frame must complete through tlast, with no new frame started.
6. rst pulsed for one cycle after payload word 2 while tready=0. Required next cycle: m_axis_tvalid=0, counters 0. A new frame after reset must start with header A5A50000.
